// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch state encoding, reset vector and byte-swap helper.
package mips_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'hBFC00000;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   // Reverse byte order of a 32-bit word (bus little-endian, ISA big-endian).
   function automatic logic [XLEN-1:0] bswap32(input logic [XLEN-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bus bundle: Avalon-MM read port, decode handoff and redirect input.
interface mips_fetch_unit_if;
   import mips_pkg::*;

   logic [XLEN-1:0] avm_address;
   logic            avm_read;
   logic [3:0]      avm_byteenable;
   logic            avm_waitrequest;
   logic [XLEN-1:0] avm_readdata;

   logic [XLEN-1:0] instr;
   logic [XLEN-1:0] instr_pc;
   logic            instr_valid;
   logic            instr_ready;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;

   // Fetch unit side.
   modport master (
      output avm_address, avm_read, avm_byteenable,
      input  avm_waitrequest, avm_readdata,
      output instr, instr_pc, instr_valid,
      input  instr_ready,
      input  redirect_valid, redirect_target
   );

   // Memory / decode / execute side.
   modport slave (
      input  avm_address, avm_read, avm_byteenable,
      output avm_waitrequest, avm_readdata,
      input  instr, instr_pc, instr_valid,
      output instr_ready,
      output redirect_valid, redirect_target
   );

endinterface

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: PC, Avalon-MM word reads, instruction register,
// delay-slot redirect handling and halt on transfer to address 0.
module mips_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter bit              BYTE_SWAP    = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   mips_fetch_unit_if.master  bus,
   output logic               active
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] ir_q;
   logic [XLEN-1:0] ir_pc_q;
   logic            pend_valid_q;
   logic [XLEN-1:0] pend_target_q;
   logic            rd_q, rd_d;
   logic            iv_q, iv_d;
   logic            act_q, act_d;

   logic            complete_c;
   logic            handoff_c;
   logic [XLEN-1:0] npc_c;
   logic [XLEN-1:0] rdata_c;

   // Returned word in ISA byte order.
   assign rdata_c = BYTE_SWAP ? bswap32(bus.avm_readdata) : bus.avm_readdata;

   // Next pc: a same-cycle redirect wins over a pending one, else sequential.
   assign npc_c = bus.redirect_valid ? bus.redirect_target :
                  pend_valid_q       ? pend_target_q       :
                                       pc_q + XLEN'(4);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // Next-state logic and next values of the registered status outputs.
   always_comb begin
      state_d    = state_q;
      complete_c = 1'b0;
      handoff_c  = 1'b0;
      case (state_q)
         FETCH: begin
            complete_c = rd_q && !bus.avm_waitrequest;
            if (complete_c) state_d = HOLD;
         end
         HOLD: begin
            handoff_c = iv_q && bus.instr_ready;
            if (handoff_c) state_d = (npc_c == '0) ? HALTED : FETCH;
         end
         HALTED: state_d = HALTED;
         default: state_d = FETCH;
      endcase
      rd_d  = (state_d == FETCH);
      iv_d  = (state_d == HOLD);
      act_d = (state_d != HALTED);
   end

   // Registered strobes so they rise one edge after the state decision.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q  <= 1'b0;
         iv_q  <= 1'b0;
         act_q <= 1'b1;
      end else begin
         rd_q  <= rd_d;
         iv_q  <= iv_d;
         act_q <= act_d;
      end
   end

   // PC advances only on a handoff that does not halt.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           pc_q <= RESET_VECTOR;
      else if (handoff_c && npc_c != '0)   pc_q <= npc_c;
   end

   // Instruction register captures the word on the completing read cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_q    <= '0;
         ir_pc_q <= '0;
      end else if (complete_c) begin
         ir_q    <= rdata_c;
         ir_pc_q <= pc_q;
      end
   end

   // Pending redirect: consumed at a handoff, otherwise latest redirect wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
      end else if (handoff_c) begin
         pend_valid_q  <= 1'b0;
      end else if (bus.redirect_valid && state_q != HALTED) begin
         pend_valid_q  <= 1'b1;
         pend_target_q <= bus.redirect_target;
      end
   end

   assign bus.avm_address    = pc_q;
   assign bus.avm_read       = rd_q;
   assign bus.avm_byteenable = 4'b1111;
   assign bus.instr          = ir_q;
   assign bus.instr_pc       = ir_pc_q;
   assign bus.instr_valid    = iv_q;
   assign active             = act_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed test-plan steps followed by
// randomized bus stalls, decode back-pressure and redirects against a
// program-order reference model.
module tb_mips_fetch_unit;

   localparam logic [31:0] RV = 32'hBFC00000;

   logic clk;
   logic reset;
   logic active;

   mips_fetch_unit_if bus();

   mips_fetch_unit #(.RESET_VECTOR(RV), .BYTE_SWAP(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .active(active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   // Reference model state: program-order view of the instruction stream.
   logic [31:0] exp_pc;        // pc of the next instruction to be handed off
   logic        redir_seen;    // a redirect arrived since the last handoff
   logic [31:0] redir_tgt;     // latest such target
   logic        halted_m;
   // Observations carried from the previous cycle.
   logic        exp_fetch;
   logic        prev_stall;
   logic        prev_complete;
   logic        prev_hold;
   logic [31:0] prev_addr;
   logic [31:0] prev_instr;
   logic [31:0] prev_ipc;

   // Program memory contents as seen on the little-endian bus.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'hBFC00000) return 32'h24020005;
      return {a[15:0], a[31:16]} ^ 32'h9E3779B9;
   endfunction

   // Big-endian view of a bus word.
   function automatic logic [31:0] be_view(input logic [31:0] w);
      logic [7:0] b0, b1, b2, b3;
      b0 = w[7:0]; b1 = w[15:8]; b2 = w[23:16]; b3 = w[31:24];
      return {b0, b1, b2, b3};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_pc        = RV;
      redir_seen    = 1'b0;
      redir_tgt     = '0;
      halted_m      = 1'b0;
      exp_fetch     = 1'b1;
      prev_stall    = 1'b0;
      prev_complete = 1'b0;
      prev_hold     = 1'b0;
      prev_addr     = '0;
      prev_instr    = '0;
      prev_ipc      = '0;
   endtask

   // Assert reset away from the clock edge, check its immediate effect, release.
   task automatic do_reset();
      #2;
      reset                = 1'b1;
      bus.avm_waitrequest  = 1'b0;
      bus.instr_ready      = 1'b0;
      bus.redirect_valid   = 1'b0;
      bus.redirect_target  = '0;
      #1;
      check("rst_read",   32'(bus.avm_read),    32'd0);
      check("rst_valid",  32'(bus.instr_valid), 32'd0);
      check("rst_active", 32'(active),          32'd1);
      check("rst_addr",   bus.avm_address,      RV);
      check("rst_instr",  bus.instr,            32'd0);
      check("rst_ipc",    bus.instr_pc,         32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   // One clock cycle: check this cycle's outputs, drive inputs, advance model.
   task automatic step(input logic wr, input logic rdy, input logic rv, input logic [31:0] rt);
      logic handoff;
      if (halted_m) begin
         check("halt_active", 32'(active),          32'd0);
         check("halt_read",   32'(bus.avm_read),    32'd0);
         check("halt_valid",  32'(bus.instr_valid), 32'd0);
      end
      if (exp_fetch) begin
         check("fetch_read", 32'(bus.avm_read), 32'd1);
         check("fetch_addr", bus.avm_address,   exp_pc);
      end
      if (prev_stall) begin
         check("stall_read",  32'(bus.avm_read),    32'd1);
         check("stall_addr",  bus.avm_address,      prev_addr);
         check("stall_valid", 32'(bus.instr_valid), 32'd0);
      end
      if (prev_complete) begin
         check("cap_valid", 32'(bus.instr_valid), 32'd1);
         check("cap_ipc",   bus.instr_pc,         prev_addr);
         check("cap_instr", bus.instr,            be_view(mem_word(prev_addr)));
      end
      if (prev_hold) begin
         check("hold_valid", 32'(bus.instr_valid), 32'd1);
         check("hold_instr", bus.instr,            prev_instr);
         check("hold_ipc",   bus.instr_pc,         prev_ipc);
         check("hold_read",  32'(bus.avm_read),    32'd0);
      end

      bus.avm_waitrequest = wr;
      bus.avm_readdata    = bus.avm_read ? mem_word(bus.avm_address) : $urandom;
      bus.instr_ready     = rdy;
      bus.redirect_valid  = rv;
      bus.redirect_target = rt;

      if (rv && !halted_m) begin
         redir_seen = 1'b1;
         redir_tgt  = rt;
      end
      handoff   = bus.instr_valid && rdy;
      exp_fetch = 1'b0;
      if (handoff) begin
         check("handoff_pc", bus.instr_pc, exp_pc);
         exp_pc     = redir_seen ? redir_tgt : exp_pc + 32'd4;
         redir_seen = 1'b0;
         if (exp_pc == 32'd0) halted_m = 1'b1;
         else                 exp_fetch = 1'b1;
      end
      prev_stall    = bus.avm_read && wr;
      prev_complete = bus.avm_read && !wr;
      prev_hold     = bus.instr_valid && !rdy;
      prev_addr     = bus.avm_address;
      prev_instr    = bus.instr;
      prev_ipc      = bus.instr_pc;

      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] rt;
      int          r;
      reset               = 1'b1;
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata    = '0;
      bus.instr_ready     = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = '0;
      model_reset();

      // Reset and first zero-wait read at the reset vector.
      do_reset();
      step(1'b0, 1'b1, 1'b0, '0);
      check("first_instr", bus.instr, 32'h05000224);
      step(1'b0, 1'b1, 1'b0, '0);

      // Three wait states on the read of 0xBFC00004.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);

      // Decode stalls five cycles in HOLD, then accepts.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);

      // Run through 0x08, 0x0C and the branch at 0x10.
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, '0);
      // Redirect raised while the delay slot 0x14 is fetched.
      step(1'b0, 1'b1, 1'b1, 32'hBFC00100);
      step(1'b0, 1'b1, 1'b0, '0);
      check("branch_target", bus.avm_address, 32'hBFC00100);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);

      // Jump to 0 from 0x100; delay slot 0x104 then halt.
      step(1'b0, 1'b1, 1'b1, 32'd0);
      step(1'b0, 1'b1, 1'b0, '0);
      check("halt_active_fall", 32'(active), 32'd0);
      for (int i = 0; i < 4; i++) step(1'($urandom), 1'b1, 1'b1, 32'h00001000);

      // Reset while a read is stalled.
      do_reset();
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      do_reset();
      check("restart_addr", bus.avm_address, RV);

      // Wrap-around: instruction at 0xFFFFFFFC falls through to 0 and halts.
      step(1'b0, 1'b1, 1'b1, 32'hFFFFFFFC);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);
      check("wrap_halted", 32'(active), 32'd0);
      do_reset();

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         if (halted_m && $urandom_range(0, 3) == 0) begin
            do_reset();
         end else begin
            r = $urandom_range(0, 49);
            if (r == 0)      rt = 32'd0;
            else if (r == 1) rt = 32'hFFFFFFFC;
            else             rt = 32'h10000000 | (32'($urandom_range(0, 1023)) << 2);
            step($urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0,
                 rt);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
